// File: rtl/instruction_fetcher.sv
// Fetch front end: owns the fetch PC, issues one word request at a time, presents the
// word to the decoder with a 2-bit-counter branch prediction, and resteers on flush.
//
// state     | meaning
// FETCH     | launch a request for the current fetch PC
// WAIT      | request outstanding, response will be presented
// HOLD      | instruction presented, waiting for the decoder to consume it
// JALR_WAIT | JALR consumed, target unknown until the RoB flushes
// DRAIN     | flushed while a request was outstanding; its response is dropped
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        pred_res,
  input  logic        issue_ready,
  input  logic        pc_change_flag,
  input  logic [31:0] pc_change,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  input  logic        br_update_valid,
  input  logic [31:0] br_update_pc,
  input  logic        br_update_taken
);

  localparam int BHT_SIZE = 1 << BHT_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_JALR_WAIT,
    S_DRAIN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic        r_req_valid, w_req_valid_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic        r_ready, w_ready_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pred, w_pred_nxt;

  logic [1:0]          r_bht [BHT_SIZE];
  logic [BHT_BITS-1:0] w_lookup_idx;
  logic [BHT_BITS-1:0] w_update_idx;
  logic                w_lookup_taken;
  logic [1:0]          w_update_ctr;
  logic [1:0]          w_update_ctr_nxt;
  logic                w_unused;

  assign w_lookup_idx   = r_fetch_pc[BHT_BITS+1:2];
  assign w_lookup_taken = r_bht[w_lookup_idx][1];
  assign w_update_idx   = br_update_pc[BHT_BITS+1:2];
  assign w_update_ctr   = r_bht[w_update_idx];
  assign w_unused       = ^{br_update_pc[31:BHT_BITS+2], br_update_pc[1:0]};

  always_comb begin
    w_update_ctr_nxt = w_update_ctr;
    if (br_update_taken) begin
      if (w_update_ctr != 2'b11) w_update_ctr_nxt = w_update_ctr + 2'd1;
    end else begin
      if (w_update_ctr != 2'b00) w_update_ctr_nxt = w_update_ctr - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    w_ready_nxt     = r_ready;
    w_inst_nxt      = r_inst;
    w_pc_nxt        = r_pc;
    w_pred_nxt      = r_pred;

    if (rob_flush) begin
      w_fetch_pc_nxt = rob_flush_pc;
      w_ready_nxt    = 1'b0;
      w_pred_nxt     = 1'b0;
      // An outstanding request must still be drained before a new one may go out.
      if ((r_state == S_WAIT || r_state == S_DRAIN) && !mem_resp_valid) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt     = S_FETCH;
        w_req_valid_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = r_fetch_pc;
          w_state_nxt     = S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            w_req_valid_nxt = 1'b0;
            w_inst_nxt      = mem_resp_data;
            w_pc_nxt        = r_fetch_pc;
            w_ready_nxt     = 1'b1;
            w_pred_nxt      = (mem_resp_data[6:0] == OP_BRANCH) && w_lookup_taken;
            w_state_nxt     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (issue_ready) begin
            w_ready_nxt = 1'b0;
            if (r_inst[6:0] == OP_JALR) begin
              w_state_nxt = S_JALR_WAIT;
            end else begin
              w_state_nxt    = S_FETCH;
              w_fetch_pc_nxt = pc_change_flag ? pc_change : r_pc + 32'd4;
            end
          end
        end
        S_JALR_WAIT: begin
        end
        S_DRAIN: begin
          if (mem_resp_valid) begin
            w_req_valid_nxt = 1'b0;
            w_state_nxt     = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_FETCH;
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'h0;
      r_ready     <= 1'b0;
      r_inst      <= 32'h0;
      r_pc        <= 32'h0;
      r_pred      <= 1'b0;
      for (int i = 0; i < BHT_SIZE; i++) r_bht[i] <= 2'b01;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_ready     <= w_ready_nxt;
      r_inst      <= w_inst_nxt;
      r_pc        <= w_pc_nxt;
      r_pred      <= w_pred_nxt;
      if (br_update_valid) r_bht[w_update_idx] <= w_update_ctr_nxt;
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign fetch_ready   = r_ready;
  assign inst          = r_inst;
  assign pc            = r_pc;
  assign pred_res      = r_pred;

endmodule
